// File: rtl/id_decode_pipe.sv
// RV32I-style instruction decode stage: register file with write-back bypass and one output register stage.
// Define ID_LOAD_USE_STALL_EN to build in the load-use interlock.
module id_decode_pipe #(
  parameter int WORD_SIZE = 32,
  parameter int NUM_REGS  = 32,
  parameter int REG_SEL   = $clog2(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WORD_SIZE-1:0] in_instr,
  input  logic [WORD_SIZE-1:0] in_pc,
  input  logic                 wb_en,
  input  logic [REG_SEL-1:0]   wb_sel,
  input  logic [WORD_SIZE-1:0] wb_data,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_SIZE-1:0] out_pc,
  output logic [WORD_SIZE-1:0] out_rs1_data,
  output logic [WORD_SIZE-1:0] out_rs2_data,
  output logic [WORD_SIZE-1:0] out_immd,
  output logic [REG_SEL-1:0]   out_rd,
  output logic [3:0]           out_alu_op,
  output logic [2:0]           out_instr_type,
  output logic                 out_use_immd,
  output logic                 out_reg_write,
  output logic                 out_mem_read,
  output logic                 out_mem_write,
  output logic                 out_illegal
);
  localparam int STAGES = 1;

  typedef enum logic [2:0] {
    T_R = 3'd0, T_I = 3'd1, T_S = 3'd2, T_B = 3'd3, T_U = 3'd4, T_J = 3'd5, T_NOP = 3'd7
  } itype_e;

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
                         ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                         ALU_OR = 4'd8, ALU_AND = 4'd9, ALU_PASSB = 4'd10;

  typedef struct packed {
    logic [WORD_SIZE-1:0] pc;
    logic [WORD_SIZE-1:0] rs1_data;
    logic [WORD_SIZE-1:0] rs2_data;
    logic [WORD_SIZE-1:0] immd;
    logic [REG_SEL-1:0]   rd;
    logic [3:0]           alu_op;
    itype_e               itype;
    logic                 use_immd;
    logic                 reg_write;
    logic                 mem_read;
    logic                 mem_write;
    logic                 illegal;
  } dec_t;

  dec_t                 dec, out_q;
  logic [STAGES:1]      vld_pipe;
  logic [WORD_SIZE-1:0] rf [NUM_REGS];
  logic [4:0]           opc;
  logic [REG_SEL-1:0]   rs1, rs2;
  logic signed [31:0]   imm32;
  logic                 hazard, xfer;
  logic                 unused_opc_lsb;

  assign opc = in_instr[6:2];
  assign rs1 = in_instr[15 +: REG_SEL];
  assign rs2 = in_instr[20 +: REG_SEL];
  assign unused_opc_lsb = ^in_instr[1:0];

  // funct7[5] selects SUB only for register-register ops; shifts honour it in both forms
  function automatic logic [3:0] alu_fn(input logic [2:0] f3, input logic alt, input logic is_r);
    case (f3)
      3'd0:    alu_fn = (is_r && alt) ? ALU_SUB : ALU_ADD;
      3'd1:    alu_fn = ALU_SLL;
      3'd2:    alu_fn = ALU_SLT;
      3'd3:    alu_fn = ALU_SLTU;
      3'd4:    alu_fn = ALU_XOR;
      3'd5:    alu_fn = alt ? ALU_SRA : ALU_SRL;
      3'd6:    alu_fn = ALU_OR;
      default: alu_fn = ALU_AND;
    endcase
  endfunction

  function automatic logic [WORD_SIZE-1:0] rf_read(input logic [REG_SEL-1:0] sel);
    if (sel == '0)                     rf_read = '0;
    else if (wb_en && wb_sel == sel)   rf_read = wb_data;
    else                               rf_read = rf[sel];
  endfunction

  always_comb begin
    dec          = '0;
    dec.itype    = T_NOP;
    dec.illegal  = 1'b1;
    dec.alu_op   = ALU_ADD;
    imm32        = '0;
    case (opc)
      5'b01100: begin dec.itype = T_R; dec.alu_op = alu_fn(in_instr[14:12], in_instr[30], 1'b1); end
      5'b00100: begin
        dec.itype  = T_I;
        dec.alu_op = alu_fn(in_instr[14:12], in_instr[30], 1'b0);
        imm32      = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      5'b00000: begin dec.itype = T_I; dec.mem_read = 1'b1; imm32 = {{20{in_instr[31]}}, in_instr[31:20]}; end
      5'b11001: begin dec.itype = T_I; imm32 = {{20{in_instr[31]}}, in_instr[31:20]}; end
      5'b01000: begin dec.itype = T_S; imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]}; end
      5'b11000: begin
        dec.itype  = T_B;
        dec.alu_op = ALU_SUB;
        imm32      = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
      end
      5'b01101: begin dec.itype = T_U; dec.alu_op = ALU_PASSB; imm32 = {in_instr[31:12], 12'b0}; end
      5'b00101: begin dec.itype = T_U; imm32 = {in_instr[31:12], 12'b0}; end
      5'b11011: begin
        dec.itype = T_J;
        imm32     = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
      end
      default: ;
    endcase
    if (dec.itype != T_NOP) dec.illegal = 1'b0;
    dec.pc        = in_pc;
    dec.rd        = in_instr[7 +: REG_SEL];
    dec.immd      = WORD_SIZE'(imm32);
    dec.use_immd  = dec.itype inside {T_I, T_S, T_U, T_J};
    dec.reg_write = (dec.itype inside {T_R, T_I, T_U, T_J}) && (dec.rd != '0);
    dec.mem_write = (dec.itype == T_S);
    dec.rs1_data  = rf_read(rs1);
    dec.rs2_data  = rf_read(rs2);
  end

`ifdef ID_LOAD_USE_STALL_EN
  logic rs1_used, rs2_used;
  assign rs1_used = dec.itype inside {T_R, T_I, T_S, T_B};
  assign rs2_used = dec.itype inside {T_R, T_S, T_B};
  // a load still sitting in the output stage has not produced its data yet
  assign hazard = vld_pipe[STAGES] & out_q.mem_read & (out_q.rd != '0) &
                  ((rs1_used & (rs1 == out_q.rd)) | (rs2_used & (rs2 == out_q.rd)));
`else
  assign hazard = 1'b0;
`endif

  assign in_ready = (!vld_pipe[STAGES] | out_ready) & !hazard & !flush;
  assign xfer     = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
    end else if (wb_en && wb_sel != '0) begin
      rf[wb_sel] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe <= '0;
      out_q    <= '0;
    end else if (flush) begin
      vld_pipe <= '0;
    end else if (xfer) begin
      vld_pipe <= '1;
      out_q    <= dec;
    end else if (out_ready) begin
      vld_pipe <= '0;
    end
  end

  assign out_valid      = vld_pipe[STAGES];
  assign out_pc         = out_q.pc;
  assign out_rs1_data   = out_q.rs1_data;
  assign out_rs2_data   = out_q.rs2_data;
  assign out_immd       = out_q.immd;
  assign out_rd         = out_q.rd;
  assign out_alu_op     = out_q.alu_op;
  assign out_instr_type = out_q.itype;
  assign out_use_immd   = out_q.use_immd;
  assign out_reg_write  = out_q.reg_write;
  assign out_mem_read   = out_q.mem_read;
  assign out_mem_write  = out_q.mem_write;
  assign out_illegal    = out_q.illegal;
endmodule

// File: tb/tb_id_decode_pipe.sv
// Bench for id_decode_pipe: decode vector table, directed handshake/hazard/reset sequences,
// and a randomized run against a transaction-level reference model.
module tb_id_decode_pipe;
  logic        clk = 0, rst = 0;
  logic        in_valid = 0, in_ready, wb_en = 0, flush = 0, out_valid, out_ready = 1;
  logic [31:0] in_instr = 0, in_pc = 0, wb_data = 0;
  logic [4:0]  wb_sel = 0;
  logic [31:0] out_pc, out_rs1_data, out_rs2_data, out_immd;
  logic [4:0]  out_rd;
  logic [3:0]  out_alu_op;
  logic [2:0]  out_instr_type;
  logic        out_use_immd, out_reg_write, out_mem_read, out_mem_write, out_illegal;

  id_decode_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .wb_en(wb_en), .wb_sel(wb_sel), .wb_data(wb_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_rs1_data(out_rs1_data),
    .out_rs2_data(out_rs2_data), .out_immd(out_immd), .out_rd(out_rd), .out_alu_op(out_alu_op),
    .out_instr_type(out_instr_type), .out_use_immd(out_use_immd), .out_reg_write(out_reg_write),
    .out_mem_read(out_mem_read), .out_mem_write(out_mem_write), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

`ifdef ID_LOAD_USE_STALL_EN
  localparam bit STALL = 1'b1;
`else
  localparam bit STALL = 1'b0;
`endif

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  ty;
    logic [3:0]  alu;
    logic        ui, rw, mr, mw, ill;
    logic [31:0] imm;
  } vec_t;

  typedef struct {
    logic [2:0]  ty;
    logic [3:0]  alu;
    logic        ui, rw, mr, mw, ill;
    logic [4:0]  rd;
    logic [31:0] imm, pc, r1, r2;
  } exp_t;

  // Reference decode built from the ISA field definitions with plain arithmetic
  function automatic exp_t ref_dec(input logic [31:0] i, input logic [31:0] pc);
    exp_t e;
    int   f3 = int'(i[14:12]);
    int   alu_tab [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
    logic [31:0] imm_i = (i[31] ? -2048 : 0) + int'(i[30:20]);
    e = '{ty: 7, alu: 0, ui: 0, rw: 0, mr: 0, mw: 0, ill: 1, rd: i[11:7], imm: 0, pc: pc, r1: 0, r2: 0};
    case (i[6:2])
      5'b01100: begin
        e.ty = 0;
        e.alu = (f3 == 0) ? (i[30] ? 1 : 0) : (f3 == 5) ? (i[30] ? 7 : 6) : alu_tab[f3];
      end
      5'b00100: begin e.ty = 1; e.imm = imm_i; e.alu = (f3 == 5 && i[30]) ? 7 : alu_tab[f3]; end
      5'b00000: begin e.ty = 1; e.imm = imm_i; e.mr = 1; end
      5'b11001: begin e.ty = 1; e.imm = imm_i; end
      5'b01000: begin e.ty = 2; e.mw = 1; e.imm = (i[31] ? -2048 : 0) + int'(i[30:25]) * 32 + int'(i[11:7]); end
      5'b11000: begin
        e.ty = 3; e.alu = 1;
        e.imm = (i[31] ? -4096 : 0) + int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
      end
      5'b01101: begin e.ty = 4; e.alu = 10; e.imm = i & 32'hFFFFF000; end
      5'b00101: begin e.ty = 4; e.imm = i & 32'hFFFFF000; end
      5'b11011: begin
        e.ty = 5;
        e.imm = (i[31] ? -(1 << 20) : 0) + int'(i[19:12]) * 4096 + int'(i[20]) * 2048 + int'(i[30:21]) * 2;
      end
      default: ;
    endcase
    if (e.ty != 7) e.ill = 0;
    e.ui = (e.ty == 1 || e.ty == 2 || e.ty == 4 || e.ty == 5);
    e.rw = (e.ty == 0 || e.ty == 1 || e.ty == 4 || e.ty == 5) && (e.rd != 0);
    return e;
  endfunction

  function automatic logic [191:0] pack_dut();
    return {out_instr_type, out_alu_op, out_use_immd, out_reg_write, out_mem_read, out_mem_write,
            out_illegal, out_rd, out_immd, out_pc, out_rs1_data, out_rs2_data};
  endfunction

  function automatic logic [191:0] pack_exp(input exp_t e);
    return {e.ty, e.alu, e.ui, e.rw, e.mr, e.mw, e.ill, e.rd, e.imm, e.pc, e.r1, e.r2};
  endfunction

  logic [31:0] rf_m [32];

  function automatic logic [31:0] rd_m(input logic [4:0] r);
    if (r == 0) return 0;
    if (wb_en && wb_sel == r) return wb_data;
    return rf_m[r];
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [31:0] i = $urandom;
    logic [4:0]  ops [9] = '{5'b01100, 5'b00100, 5'b00000, 5'b11001, 5'b01000,
                             5'b11000, 5'b01101, 5'b00101, 5'b11011};
    int k = $urandom_range(0, 10);
    if (k < 9) i[6:2] = ops[k];
    i[1:0]   = 2'b11;
    i[11:7]  = 5'($urandom_range(0, 7));
    i[19:15] = 5'($urandom_range(0, 7));
    i[24:20] = 5'($urandom_range(0, 7));
    return i;
  endfunction

  vec_t vt [$];
  exp_t me, cand;
  bit   mv, hz, er;

  initial begin
    vt.push_back('{32'hFFF28313, 3'd1, 4'd0,  1, 1, 0, 0, 0, 32'hFFFFFFFF}); // addi x6,x5,-1
    vt.push_back('{32'h00738433, 3'd0, 4'd0,  0, 1, 0, 0, 0, 32'h0});        // add
    vt.push_back('{32'h403100B3, 3'd0, 4'd1,  0, 1, 0, 0, 0, 32'h0});        // sub
    vt.push_back('{32'h40335293, 3'd1, 4'd7,  1, 1, 0, 0, 0, 32'h403});      // srai
    vt.push_back('{32'h0000A183, 3'd1, 4'd0,  1, 1, 1, 0, 0, 32'h0});        // lw
    vt.push_back('{32'h0020A423, 3'd2, 4'd0,  1, 0, 0, 1, 0, 32'h8});        // sw
    vt.push_back('{32'hFE208EE3, 3'd3, 4'd1,  0, 0, 0, 0, 0, 32'hFFFFFFFC}); // beq -4
    vt.push_back('{32'h12345537, 3'd4, 4'd10, 1, 1, 0, 0, 0, 32'h12345000}); // lui
    vt.push_back('{32'h80000017, 3'd4, 4'd0,  1, 0, 0, 0, 0, 32'h80000000}); // auipc x0
    vt.push_back('{32'hFF9FF0EF, 3'd5, 4'd0,  1, 1, 0, 0, 0, 32'hFFFFFFF8}); // jal -8
    vt.push_back('{32'h00008067, 3'd1, 4'd0,  1, 0, 0, 0, 0, 32'h0});        // jalr x0
    vt.push_back('{32'h00000FFF, 3'd7, 4'd0,  0, 0, 0, 0, 1, 32'h0});        // illegal
    vt.push_back('{32'h0020B4B3, 3'd0, 4'd4,  0, 1, 0, 0, 0, 32'h0});        // sltu
    vt.push_back('{32'h07F17113, 3'd1, 4'd9,  1, 1, 0, 0, 0, 32'h7F});       // andi

    // reset state
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_fields", pack_dut(), 0);
    rst = 1;
    #1 chk("rst_in_ready", in_ready, 1);
    tick();

    // decode table, back-to-back with out_ready=1
    foreach (vt[k]) begin
      in_valid = 1; in_instr = vt[k].instr; in_pc = k * 4;
      #1 chk("tbl_in_ready", in_ready, 1);
      tick();
      chk("tbl_valid", out_valid, 1);
      chk("tbl_fields",
          {out_instr_type, out_alu_op, out_use_immd, out_reg_write, out_mem_read, out_mem_write, out_illegal, out_immd},
          {vt[k].ty, vt[k].alu, vt[k].ui, vt[k].rw, vt[k].mr, vt[k].mw, vt[k].ill, vt[k].imm});
      chk("tbl_pc", out_pc, k * 4);
    end
    in_valid = 0; tick();

    // write-back then dependent addi
    wb_en = 1; wb_sel = 5; wb_data = 32'h1234; tick();
    wb_en = 0; in_valid = 1; in_instr = 32'hFFF28313; tick();
    in_valid = 0;
    chk("addi_rs1", out_rs1_data, 32'h1234);
    chk("addi_imm", out_immd, 32'hFFFFFFFF);
    chk("addi_ctl", {out_alu_op, out_use_immd, out_reg_write}, {4'd0, 1'b1, 1'b1});

    // same-cycle write-back bypass
    wb_en = 1; wb_sel = 7; wb_data = 32'hAA; in_valid = 1; in_instr = 32'h00738433; tick();
    wb_en = 0; in_valid = 0;
    chk("bypass_rs", {out_rs1_data, out_rs2_data}, {32'hAA, 32'hAA});

    // backpressure: hold SUB for 3 cycles while SLTU waits
    in_valid = 1; in_instr = 32'h403100B3; tick();
    out_ready = 0; in_instr = 32'h0020B4B3;
    for (int c = 0; c < 3; c++) begin
      #1 chk("bp_in_ready", in_ready, 0);
      tick();
      chk("bp_hold", {out_valid, out_rd, out_alu_op}, {1'b1, 5'd1, 4'd1});
    end
    out_ready = 1;
    #1 chk("bp_release_ready", in_ready, 1);
    tick();
    chk("bp_next", {out_valid, out_rd, out_alu_op}, {1'b1, 5'd9, 4'd4});

    // load-use: lw x3 held, then add x4,x3,x2
    in_instr = 32'h0000A183; tick();
    out_ready = 0; in_instr = 32'h00218233;
    #1 chk("lu_hold_ready", in_ready, 0);
    tick();
    out_ready = 1;
    #1 chk("lu_in_ready", in_ready, !STALL);
    tick();
    if (STALL) begin
      chk("lu_bubble", out_valid, 0);
      chk("lu_after_ready", in_ready, 1);
      tick();
    end
    chk("lu_add_out", {out_valid, out_rd, out_mem_read}, {1'b1, 5'd4, 1'b0});

    // flush drops held output and presented input; write-back still lands
    out_ready = 0; flush = 1; wb_en = 1; wb_sel = 12; wb_data = 32'h55;
    #1 chk("flush_in_ready", in_ready, 0);
    tick();
    flush = 0; wb_en = 0; in_valid = 0; out_ready = 1;
    chk("flush_valid", out_valid, 0);
    tick();
    chk("flush_dropped", out_valid, 0);
    in_valid = 1; in_instr = 32'h000600B3; tick();
    in_valid = 0;
    chk("flush_wb_rs1", out_rs1_data, 32'h55);

    // reset mid-stream
    wb_en = 1; wb_sel = 31; wb_data = 32'hDEAD; tick(); wb_en = 0;
    in_valid = 1; in_instr = 32'h0020B4B3; out_ready = 0; tick();
    #2 rst = 0;
    #1 chk("midrst_valid", out_valid, 0);
    chk("midrst_fields", pack_dut(), 0);
    tick();
    rst = 1; in_valid = 0; out_ready = 1;
    #1 chk("midrst_in_ready", in_ready, 1);
    tick();
    for (int r = 1; r < 32; r++) begin
      in_valid = 1; in_instr = {7'b0, 5'(r), 5'(r), 3'b0, 5'd1, 7'b0110011}; tick();
      chk("midrst_rf_zero", {out_rs1_data, out_rs2_data}, 64'h0);
    end
    in_valid = 0; tick();

    // randomized run against the reference model
    foreach (rf_m[r]) rf_m[r] = 0;
    mv = 0;
    for (int c = 0; c < 800; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_instr  = rnd_instr();
      in_pc     = $urandom;
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 19) == 0);
      wb_en     = $urandom_range(0, 1);
      wb_sel    = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      wb_data   = $urandom;
      #1;
      cand    = ref_dec(in_instr, in_pc);
      cand.r1 = rd_m(in_instr[19:15]);
      cand.r2 = rd_m(in_instr[24:20]);
      hz = STALL && mv && me.mr && me.rd != 0 &&
           ((cand.ty <= 3 && in_instr[19:15] == me.rd) ||
            ((cand.ty == 0 || cand.ty == 2 || cand.ty == 3) && in_instr[24:20] == me.rd));
      er = (!mv || out_ready) && !hz && !flush;
      chk("rnd_in_ready", in_ready, er);
      @(posedge clk);
      if (flush) mv = 0;
      else if (in_valid && er) begin mv = 1; me = cand; end
      else if (out_ready) mv = 0;
      if (wb_en && wb_sel != 0) rf_m[wb_sel] = wb_data;
      #1;
      chk("rnd_out_valid", out_valid, mv);
      if (mv) chk("rnd_fields", pack_dut(), pack_exp(me));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
